// File: rtl/comp_pkg.sv
// Shared types for the serial nibble-cascade comparator: FSM states,
// cascade result encoding and the nibble width.
package comp_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCUM  = 2'b01,
      ST_RESULT = 2'b10
   } fsm_state_e;

   typedef enum logic [1:0] {
      CASC_EQ = 2'b00,
      CASC_LT = 2'b01,
      CASC_GT = 2'b10
   } casc_e;

   // Maps a cascade state onto the {eq, lt, gt} one-hot output vector.
   function automatic logic [2:0] casc_onehot(input casc_e c);
      logic [2:0] oh;
      case (c)
         CASC_EQ: oh = 3'b100;
         CASC_LT: oh = 3'b010;
         CASC_GT: oh = 3'b001;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/nib_cmp.sv
// One stage of the magnitude cascade: an undecided (EQ) input is resolved by
// an unsigned nibble compare, a decided input passes straight through.
module nib_cmp
   import comp_pkg::*;
(
   input  logic [NIB_W-1:0] a_nib,
   input  logic [NIB_W-1:0] b_nib,
   input  casc_e            casc_in,
   output casc_e            casc_out
);

   // Cascade resolution for the current nibble pair.
   always_comb begin
      casc_out = casc_in;
      if (casc_in != CASC_EQ) begin
         casc_out = casc_in;
      end else if (a_nib < b_nib) begin
         casc_out = CASC_LT;
      end else if (a_nib > b_nib) begin
         casc_out = CASC_GT;
      end else begin
         casc_out = CASC_EQ;
      end
   end

endmodule

// File: rtl/serial_cascade_comp.sv
// Serial magnitude comparator: operands arrive MSB nibble first over a
// valid/ready stream, the one-hot verdict is held until the consumer takes it.
module serial_cascade_comp
   import comp_pkg::*;
#(
   parameter int MAX_NIBBLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_first,
   input  logic             in_last,
   input  logic [NIB_W-1:0] a_nib,
   input  logic [NIB_W-1:0] b_nib,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_eq_b,
   output logic             a_ls_b,
   output logic             a_gt_b,
   output logic             proto_err
);

   localparam int              CNT_W   = $clog2(MAX_NIBBLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NIBBLES);

   fsm_state_e       state_r;
   fsm_state_e       state_nxt_s;
   casc_e            casc_r;
   casc_e            casc_nxt_s;
   casc_e            casc_in_s;
   casc_e            casc_out_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] beat_cnt_s;
   logic             accept_s;
   logic             overflow_s;
   logic             end_s;
   logic             perr_nxt_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [2:0]       res_r;
   logic             proto_err_r;

   // A first beat ignores history, so it enters the cascade as undecided.
   assign casc_in_s  = in_first ? CASC_EQ : casc_r;
   assign beat_cnt_s = in_first ? CNT_W'(1'b1) : (cnt_r + CNT_W'(1'b1));
   assign overflow_s = !in_last && (beat_cnt_s >= CNT_MAX);
   assign end_s      = in_last || overflow_s;
   assign accept_s   = in_valid && in_ready_r;

   nib_cmp u_nib_cmp (
      .a_nib    (a_nib),
      .b_nib    (b_nib),
      .casc_in  (casc_in_s),
      .casc_out (casc_out_s)
   );

   // Next-state, cascade, counter and protocol-error decode.
   always_comb begin
      state_nxt_s = state_r;
      casc_nxt_s  = casc_r;
      cnt_nxt_s   = cnt_r;
      perr_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && in_first) begin
               casc_nxt_s  = casc_out_s;
               cnt_nxt_s   = beat_cnt_s;
               perr_nxt_s  = overflow_s;
               state_nxt_s = end_s ? ST_RESULT : ST_ACCUM;
            end else if (accept_s) begin
               perr_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (accept_s) begin
               casc_nxt_s  = casc_out_s;
               cnt_nxt_s   = beat_cnt_s;
               perr_nxt_s  = in_first || overflow_s;
               state_nxt_s = end_s ? ST_RESULT : ST_ACCUM;
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         ST_RESULT: begin
            if (out_ready) begin
               state_nxt_s = ST_IDLE;
               casc_nxt_s  = CASC_EQ;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = ST_RESULT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            casc_nxt_s  = CASC_EQ;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and registered outputs; outputs are derived from the next state so
   // out_valid and the verdict appear on the edge that accepts the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         casc_r      <= CASC_EQ;
         cnt_r       <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         res_r       <= 3'b000;
         proto_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         casc_r      <= casc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         in_ready_r  <= (state_nxt_s != ST_RESULT);
         out_valid_r <= (state_nxt_s == ST_RESULT);
         res_r       <= (state_nxt_s == ST_RESULT) ? casc_onehot(casc_nxt_s) : 3'b000;
         proto_err_r <= perr_nxt_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign a_eq_b    = res_r[2];
   assign a_ls_b    = res_r[1];
   assign a_gt_b    = res_r[0];
   assign proto_err = proto_err_r;

endmodule

// File: tb/tb_serial_cascade_comp.sv
// Scoreboard bench for serial_cascade_comp: the driver feeds beats into an
// operand-level reference model, a negedge monitor checks every DUT output.
module tb_serial_cascade_comp;

   localparam int MAXN = 4;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_first;
   logic       in_last;
   logic [3:0] a_nib;
   logic [3:0] b_nib;
   logic       out_valid;
   logic       out_ready;
   logic       a_eq_b;
   logic       a_ls_b;
   logic       a_gt_b;
   logic       proto_err;

   int n_checks = 0;
   int n_errors = 0;
   int or_mode  = 1;   // 0 random, 1 always ready, 2 stalled

   logic [2:0] res_q[$];
   bit         perr_q[$];
   bit         end_q[$];

   bit     m_active = 1'b0;
   int     m_n = 0;
   longint m_a = 0;
   longint m_b = 0;

   serial_cascade_comp #(.MAX_NIBBLES(MAXN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .a_nib     (a_nib),
      .b_nib     (b_nib),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_eq_b    (a_eq_b),
      .a_ls_b    (a_ls_b),
      .a_gt_b    (a_gt_b),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: collect whole operands as integers and compare them numerically.
   task automatic model_beat(input logic [3:0] a, input logic [3:0] b, input bit f, input bit l);
      bit perr = 1'b0;
      bit ends = 1'b0;
      if (!m_active && !f) begin
         perr = 1'b1;
      end else begin
         if (f) begin
            if (m_active) perr = 1'b1;
            m_a = 0;
            m_b = 0;
            m_n = 0;
            m_active = 1'b1;
         end
         m_a = m_a * 16 + longint'(a);
         m_b = m_b * 16 + longint'(b);
         m_n++;
         if (l || m_n == MAXN) begin
            if (!l) perr = 1'b1;
            ends = 1'b1;
            m_active = 1'b0;
            if (m_a < m_b)      res_q.push_back(3'b010);
            else if (m_a > m_b) res_q.push_back(3'b001);
            else                res_q.push_back(3'b100);
         end
      end
      perr_q.push_back(perr);
      end_q.push_back(ends);
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input bit f, input bit l);
      int waited = 0;
      bit done = 1'b0;
      a_nib = a; b_nib = b; in_first = f; in_last = l; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            model_beat(a, b, f, l);
            done = 1'b1;
         end else begin
            waited++;
            if (waited > 50) begin
               check("accept_timeout", 32'd0, 32'd1);
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (or_mode)
         0:       out_ready = ($urandom_range(0, 3) != 0);
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   bit         acc_prev = 1'b0;
   bit         prev_hold = 1'b0;
   logic [2:0] prev_res = 3'b000;

   // Monitor: protocol error, latency, hold stability, one-hot and scoreboard.
   always @(negedge clk) begin
      logic [2:0] res;
      res = {a_eq_b, a_ls_b, a_gt_b};
      if (acc_prev && perr_q.size() > 0) begin
         check("proto_err", 32'(proto_err), 32'(perr_q.pop_front()));
         if (end_q.pop_front()) check("latency_out_valid", 32'(out_valid), 32'd1);
      end else begin
         check("proto_err_quiet", 32'(proto_err), 32'd0);
      end
      if (prev_hold) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_stable", 32'(res), 32'(prev_res));
      end
      if (out_valid) begin
         check("onehot", 32'($countones(res)), 32'd1);
         check("ready_low_in_result", 32'(in_ready), 32'd0);
         if (out_ready) begin
            if (res_q.size() == 0) check("unexpected_result", 32'd0, 32'd1);
            else                   check("result", 32'(res), 32'(res_q.pop_front()));
         end
      end else begin
         check("idle_zero", 32'(res), 32'd0);
      end
      acc_prev  = rst_n && in_valid && in_ready;
      prev_hold = out_valid && !out_ready;
      prev_res  = res;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         len;
      int         fault;
      logic [3:0] ra;
      logic [3:0] rb;
      bit         rf;
      bit         rl;

      rst_n = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      a_nib = 4'h0; b_nib = 4'h0; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_results", 32'({a_eq_b, a_ls_b, a_gt_b}), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      idle(2);
      rst_n = 1'b1;

      // Equal operands; result present for exactly one cycle with ready high.
      send_beat(4'h5, 4'h5, 1'b1, 1'b0);
      send_beat(4'hA, 4'hA, 1'b0, 1'b1);
      check("eq_result", 32'(a_eq_b), 32'd1);
      check("eq_valid", 32'(out_valid), 32'd1);
      check("eq_no_perr", 32'(proto_err), 32'd0);
      idle(1);
      check("eq_valid_one_cycle", 32'(out_valid), 32'd0);

      // Decided LT in the first nibble survives F vs 0.
      send_beat(4'h3, 4'h4, 1'b1, 1'b0);
      send_beat(4'hF, 4'h0, 1'b0, 1'b1);
      check("lt_result", 32'(a_ls_b), 32'd1);
      idle(2);

      // Single-beat GT held under back-pressure.
      or_mode = 2; out_ready = 1'b0;
      send_beat(4'h9, 4'h2, 1'b1, 1'b1);
      check("gt_result", 32'(a_gt_b), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_gt", 32'(a_gt_b), 32'd1);
      end
      @(posedge clk); #1;
      or_mode = 1; out_ready = 1'b1;
      idle(2);

      // Missing first in IDLE, then a restart mid-comparison.
      send_beat(4'h1, 4'h2, 1'b0, 1'b0);
      check("idle_nofirst_perr", 32'(proto_err), 32'd1);
      check("idle_nofirst_dropped", 32'(out_valid), 32'd0);
      send_beat(4'h1, 4'h1, 1'b1, 1'b0);
      send_beat(4'h2, 4'h2, 1'b0, 1'b0);
      send_beat(4'h7, 4'h3, 1'b1, 1'b0);
      check("restart_perr", 32'(proto_err), 32'd1);
      send_beat(4'h1, 4'h9, 1'b0, 1'b1);
      check("restart_gt", 32'(a_gt_b), 32'd1);
      idle(2);

      // Overflow: no in_last within MAX_NIBBLES beats, then a stray fifth beat.
      send_beat(4'h4, 4'h4, 1'b1, 1'b0);
      send_beat(4'h4, 4'h4, 1'b0, 1'b0);
      send_beat(4'h4, 4'h4, 1'b0, 1'b0);
      send_beat(4'h3, 4'h4, 1'b0, 1'b0);
      check("ovf_valid", 32'(out_valid), 32'd1);
      check("ovf_perr", 32'(proto_err), 32'd1);
      check("ovf_lt", 32'(a_ls_b), 32'd1);
      send_beat(4'h8, 4'h1, 1'b0, 1'b0);
      check("ovf_extra_perr", 32'(proto_err), 32'd1);
      idle(2);

      // Asynchronous reset in the middle of a comparison.
      send_beat(4'h1, 4'h1, 1'b1, 1'b0);
      send_beat(4'h2, 4'h3, 1'b0, 1'b0);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_results", 32'({a_eq_b, a_ls_b, a_gt_b}), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      m_active = 1'b0;
      m_n = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_beat(4'h6, 4'h6, 1'b1, 1'b0);
      send_beat(4'h0, 4'h1, 1'b0, 1'b1);
      check("postrst_lt", 32'(a_ls_b), 32'd1);
      idle(2);

      // Randomized traffic with occasional protocol faults and random back-pressure.
      or_mode = 0;
      for (int t = 0; t < 300; t++) begin
         len   = $urandom_range(1, MAXN);
         fault = $urandom_range(0, 9);
         for (int i = 0; i < len; i++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom);
            rf = (i == 0);
            rl = (i == len - 1);
            if (fault == 0 && i == 0) rf = 1'b0;
            if (fault == 1 && rl) rl = 1'b0;
            if (fault == 2 && i == len - 1 && len > 1) rf = 1'b1;
            send_beat(ra, rb, rf, rl);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
      or_mode = 1;
      idle(6);
      check("results_drained", 32'(res_q.size()), 32'd0);
      check("perr_drained", 32'(perr_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_cascade_comp.md
SERIAL_CASCADE_COMP -- requirements
Module: serial_cascade_comp

Interface
REQ-001 The block SHALL have parameter MAX_NIBBLES, default 4, giving the maximum number of nibbles per comparison (operand width 4*MAX_NIBBLES).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a nibble pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a nibble pair this cycle.
REQ-006 The block SHALL have port in_first, input, 1, meaning the beat is the most significant nibble pair.
REQ-007 The block SHALL have port in_last, input, 1, meaning the beat is the least significant nibble pair.
REQ-008 The block SHALL have ports a_nib and b_nib, input, 4 each, holding the current nibble of operands A and B.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is held.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have ports a_eq_b, a_ls_b and a_gt_b, output, 1 each, giving a one-hot result that is valid while out_valid=1.
REQ-012 The block SHALL have port proto_err, output, 1, a one-cycle pulse on a protocol violation.

Function
REQ-013 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in RESULT.
REQ-014 FSM states SHALL be IDLE, ACCUM and RESULT.
REQ-015 The running cascade state SHALL be EQ, LT or GT.
- A beat with in_first SHALL load the state from the nibble compare alone.
- Any other accepted beat SHALL update the state only if the current state is EQ; otherwise the state holds.
REQ-016 Nibble compare SHALL be unsigned 4-bit.
REQ-017 IDLE transitions:
- Accepted beat with in_first: go to ACCUM, or to RESULT if in_last is also 1.
- Accepted beat without in_first: drop the beat, pulse proto_err, stay in IDLE.
REQ-018 ACCUM transitions:
- Accepted beat with in_last: go to RESULT.
- Accepted beat with in_first: restart the comparison with that beat (prior beats discarded), pulse proto_err; the in_last rule still applies.
REQ-019 A nibble counter SHALL count accepted beats of the current comparison. If a beat would exceed MAX_NIBBLES without in_last, it SHALL be treated as last: go to RESULT and pulse proto_err.
REQ-020 In RESULT, out_valid SHALL be 1 and the result SHALL be stable until out_ready=1. On out_ready=1 the FSM SHALL go to IDLE the next cycle.
REQ-021 Latency: out_valid SHALL rise on the clock edge that accepts the last beat, i.e. it is visible in the cycle after that beat.
REQ-022 When out_valid=0, a_eq_b, a_ls_b and a_gt_b SHALL all be 0.
REQ-023 When out_valid=1, exactly one of a_eq_b, a_ls_b and a_gt_b SHALL be 1.
REQ-024 in_valid SHALL be ignored during RESULT, with no proto_err.

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously set the following, regardless of state or an in-progress comparison: FSM=IDLE, cascade state=EQ, counter=0, out_valid=0, all result outputs 0, proto_err=0, in_ready=1.
REQ-026 Reset release SHALL be synchronous-safe: the first accepted beat is possible on the first rising edge with rst_n=1.

Structure
REQ-027 Shared package comp_pkg SHALL hold the FSM state enum, the cascade result enum (EQ/LT/GT) and the nibble width constant (4).
REQ-028 Sub-module nib_cmp SHALL be a combinational 4-bit compare taking cascade-in EQ/LT/GT and producing cascade-out EQ/LT/GT; it is instantiated once.
REQ-029 Target size is 120-400 lines of RTL.

Verification
REQ-030 Beats A=0x5A, B=0x5A (2 beats, first then last), out_ready=1 -> a_eq_b=1 with out_valid=1 for one cycle, no proto_err.
REQ-031 Beats A=0x3F, B=0x40 -> after beat 1 the state is LT; beat 2 (F vs 0) does not change it -> a_ls_b=1.
REQ-032 Single beat with in_first=in_last=1, A=0x9, B=0x2 -> a_gt_b=1 in the next cycle; hold out_ready=0 for 5 cycles -> output stable and in_ready=0 throughout.
REQ-033 Beat without in_first in IDLE -> one-cycle proto_err, beat dropped; then a first beat with in_first in ACCUM mid-comparison -> proto_err and restart from the new nibble.
REQ-034 MAX_NIBBLES=4 with 5 beats and no in_last -> RESULT after beat 4 with proto_err; rst_n pulsed low mid-ACCUM -> immediate IDLE, all outputs 0, and the next comparison is correct.
